// File: rtl/lcd_reader_if.sv
// Sequencer-side and LCD-pin signals of the 4-bit LCD reader.
interface lcd_reader_if;
  logic       read_request;
  logic       read_rs;
  logic       read_poll;
  logic [3:0] lcd_data;
  logic       ready;
  logic       read_valid;
  logic [7:0] read_data;
  logic       timeout;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_sf;

  modport master (
    output read_request, read_rs, read_poll, lcd_data,
    input  ready, read_valid, read_data, timeout, lcd_e, lcd_rs, lcd_rw, lcd_sf
  );

  modport slave (
    input  read_request, read_rs, read_poll, lcd_data,
    output ready, read_valid, read_data, timeout, lcd_e, lcd_rs, lcd_rw, lcd_sf
  );
endinterface

// File: rtl/lcd_reader.sv
// HD44780 4-bit read engine: RS/RW setup, two E pulses, {MSN,LSN} assembly, optional BF polling.
// One 16-bit down counter times every state; all pin and handshake outputs are registered.
module lcd_reader #(
  parameter int SETUP_CYCLES  = 2,
  parameter int E_HIGH_CYCLES = 12,
  parameter int HOLD_CYCLES   = 1,
  parameter int GAP_CYCLES    = 50,
  parameter int POLL_LIMIT    = 1000
) (
  input  logic        clk,
  input  logic        rst,
  lcd_reader_if.slave bus
);
  localparam logic [15:0] SETUP_LD = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] E_LD     = 16'(E_HIGH_CYCLES - 1);
  localparam logic [15:0] HOLD_LD  = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] GAP_LD   = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] LIMIT    = 16'(POLL_LIMIT);

  typedef enum logic [2:0] {
    IDLE, SETUP, E_MSN, HOLD_MSN, GAP, E_LSN, HOLD_LSN, DONE
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] poll_cnt;
  logic        poll;
  logic        second_nibble;
  logic [3:0]  msn;
  logic [3:0]  lsn;
  logic        ready;
  logic        read_valid;
  logic        timeout;
  logic [7:0]  read_data;
  logic        lcd_e;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        cnt_zero;

  assign cnt_zero       = (cnt == 16'd0);
  assign bus.ready      = ready;
  assign bus.read_valid = read_valid;
  assign bus.read_data  = read_data;
  assign bus.timeout    = timeout;
  assign bus.lcd_e      = lcd_e;
  assign bus.lcd_rs     = lcd_rs;
  assign bus.lcd_rw     = lcd_rw;
  assign bus.lcd_sf     = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 16'd0;
      poll_cnt      <= 16'd0;
      poll          <= 1'b0;
      second_nibble <= 1'b0;
      msn           <= 4'h0;
      lsn           <= 4'h0;
      ready         <= 1'b1;
      read_valid    <= 1'b0;
      timeout       <= 1'b0;
      read_data     <= 8'h00;
      lcd_e         <= 1'b0;
      lcd_rs        <= 1'b0;
      lcd_rw        <= 1'b0;
    end else begin
      read_valid <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        IDLE: if (bus.read_request) begin
          lcd_rs   <= bus.read_rs;
          lcd_rw   <= 1'b1;
          poll     <= bus.read_poll & ~bus.read_rs;
          poll_cnt <= 16'd0;
          ready    <= 1'b0;
          cnt      <= SETUP_LD;
          state    <= SETUP;
        end
        SETUP: if (cnt_zero) begin
          lcd_e <= 1'b1;
          cnt   <= E_LD;
          state <= E_MSN;
        end else cnt <= cnt - 16'd1;
        E_MSN: if (cnt_zero) begin
          msn   <= bus.lcd_data;
          lcd_e <= 1'b0;
          cnt   <= HOLD_LD;
          state <= HOLD_MSN;
        end else cnt <= cnt - 16'd1;
        HOLD_MSN: if (cnt_zero) begin
          second_nibble <= 1'b1;
          cnt           <= GAP_LD;
          state         <= GAP;
        end else cnt <= cnt - 16'd1;
        // GAP is shared: MSN->LSN spacing, and E-low spacing before the next poll read.
        GAP: if (cnt_zero) begin
          if (second_nibble) begin
            lcd_e <= 1'b1;
            cnt   <= E_LD;
            state <= E_LSN;
          end else begin
            cnt   <= SETUP_LD;
            state <= SETUP;
          end
        end else cnt <= cnt - 16'd1;
        E_LSN: if (cnt_zero) begin
          lsn   <= bus.lcd_data;
          lcd_e <= 1'b0;
          cnt   <= HOLD_LD;
          state <= HOLD_LSN;
        end else cnt <= cnt - 16'd1;
        HOLD_LSN: if (cnt_zero) begin
          state <= DONE;
          if (poll && msn[3]) begin
            poll_cnt <= poll_cnt + 16'd1;
            if (poll_cnt + 16'd1 == LIMIT) begin
              read_valid <= 1'b1;
              timeout    <= 1'b1;
              read_data  <= {msn, lsn};
            end
          end else begin
            read_valid <= 1'b1;
            read_data  <= {msn, lsn};
          end
        end else cnt <= cnt - 16'd1;
        DONE: if (read_valid) begin
          ready  <= 1'b1;
          lcd_rw <= 1'b0;
          lcd_rs <= 1'b0;
          state  <= IDLE;
        end else begin
          second_nibble <= 1'b0;
          cnt           <= GAP_LD;
          state         <= GAP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_reader.sv
// Bench for lcd_reader: LCD nibble responder, cycle-level expectation model, directed scenarios.
module tb_lcd_reader;
  localparam int SETUP  = 2;
  localparam int EH     = 12;
  localparam int HOLD   = 1;
  localparam int GAP    = 50;
  localparam int LIMIT  = 4;
  localparam int DONE_Q = SETUP + 2*EH + 2*HOLD + GAP;  // cycle offset of result within one read
  localparam int PER    = DONE_Q + 1 + GAP;             // spacing of successive poll reads

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  int   txn_id = 0;
  logic [3:0] nib [32];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_reader_if bus();

  lcd_reader #(
    .SETUP_CYCLES(SETUP), .E_HIGH_CYCLES(EH), .HOLD_CYCLES(HOLD),
    .GAP_CYCLES(GAP), .POLL_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < 0 || i >= q.size()) return -1;
    return q[i];
  endfunction

  // LCD device: each E pulse returns the next table nibble, valid only after E has been high a cycle.
  int lcd_p = 0, lcd_cnt = 0, lcd_txn = 0;
  initial begin
    logic [3:0] cur;
    bus.lcd_data = 4'h0;
    forever begin
      @(posedge clk);
      #2;
      if (txn_id != lcd_txn) begin
        lcd_txn = txn_id;
        lcd_p   = 0;
        lcd_cnt = 0;
      end
      if (bus.lcd_e === 1'b1) begin
        lcd_cnt++;
        cur = nib[lcd_p % 32];
        bus.lcd_data = (lcd_cnt >= 2) ? cur : ~cur;
      end else begin
        if (lcd_cnt > 0) lcd_p++;
        lcd_cnt = 0;
        bus.lcd_data = ~nib[lcd_p % 32];
      end
    end
  end

  // Expectation model: a transaction is a count of reads, each a fixed-length timeline.
  logic       m_started = 1'b0, m_act = 1'b0, m_rs = 1'b0, m_poll = 1'b0, m_tofl = 1'b0;
  logic       m_valid = 1'b0, m_to = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         m_c = 0, m_done = 0, m_n = 0, m_pb = 0, m_txn = 0;

  function automatic logic e_phase(input int c);
    int q;
    q = (c - 1) % PER;
    return (q >= SETUP && q < SETUP + EH) ||
           (q >= SETUP + EH + HOLD + GAP && q < SETUP + 2*EH + HOLD + GAP);
  endfunction

  always @(posedge clk) begin
    if (txn_id != m_txn) begin
      m_txn = txn_id;
      m_pb  = 0;
    end
    m_valid = 1'b0;
    m_to    = 1'b0;
    if (rst) begin
      m_started = 1'b1;
      m_act     = 1'b0;
      m_data    = 8'h00;
    end else if (m_started) begin
      if (m_act) begin
        if (m_c == m_done) begin
          m_act = 1'b0;
          m_pb  = m_pb + 2*m_n;
        end else m_c++;
      end else if (bus.read_request) begin
        m_act  = 1'b1;
        m_c    = 1;
        m_rs   = bus.read_rs;
        m_poll = bus.read_poll & ~bus.read_rs;
        m_n    = 1;
        m_tofl = 1'b0;
        if (m_poll) begin
          for (int i = 0; i < LIMIT; i++) begin
            m_n = i + 1;
            if (!nib[(m_pb + 2*i) % 32][3]) break;
            if (i + 1 == LIMIT) m_tofl = 1'b1;
          end
        end
        m_done = 1 + PER*(m_n - 1) + DONE_Q;
      end
      if (m_act && m_c == m_done) begin
        m_valid = 1'b1;
        m_to    = m_tofl;
        m_data  = {nib[(m_pb + 2*m_n - 2) % 32], nib[(m_pb + 2*m_n - 1) % 32]};
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("ready",   32'(bus.ready),      32'(!m_act));
      chk("lcd_e",   32'(bus.lcd_e),      32'(m_act && e_phase(m_c)));
      chk("lcd_rw",  32'(bus.lcd_rw),     32'(m_act));
      chk("lcd_rs",  32'(bus.lcd_rs),     32'(m_act && m_rs));
      chk("valid",   32'(bus.read_valid), 32'(m_valid));
      chk("timeout", 32'(bus.timeout),    32'(m_to));
      chk("data",    32'(bus.read_data),  32'(m_data));
      chk("sf",      32'(bus.lcd_sf),     32'h1);
    end
  end

  // Event log, indexed by cycle number (cycle j ends at edge j).
  logic prev_e = 1'b0;
  int v_idx[$], v_dat[$], v_to[$], e_rise[$], e_fall[$];
  always @(negedge clk) begin
    if (m_started) begin
      if (bus.read_valid === 1'b1) begin
        v_idx.push_back(cyc + 1);
        v_dat.push_back(int'(bus.read_data));
        v_to.push_back(int'(bus.timeout));
      end
      if (bus.lcd_e === 1'b1 && !prev_e) e_rise.push_back(cyc + 1);
      if (bus.lcd_e !== 1'b1 && prev_e)  e_fall.push_back(cyc + 1);
      prev_e = (bus.lcd_e === 1'b1);
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      nchk++;
      nerr++;
      $display("FAIL wait_ready: ready still %b after %0d cycles, required 1", bus.ready, n);
    end
  endtask

  // Returns k = number of the edge that accepted the request.
  task automatic start_read(input logic rs, input logic poll, output int k);
    wait_ready();
    txn_id++;
    bus.read_rs      = rs;
    bus.read_poll    = poll;
    bus.read_request = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    bus.read_request = 1'b0;
    bus.read_rs      = ~rs;
    bus.read_poll    = ~poll;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", nerr);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, b, r, bad, mn;
    bus.read_request = 1'b0;
    bus.read_rs      = 1'b0;
    bus.read_poll    = 1'b0;
    for (int i = 0; i < 32; i++) nib[i] = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'h1);
    chk("rst_data",  32'(bus.read_data), 32'h0);
    chk("rst_e",     32'(bus.lcd_e), 32'h0);
    chk("rst_rw",    32'(bus.lcd_rw), 32'h0);
    chk("rst_valid", 32'(bus.read_valid), 32'h0);
    chk("rst_sf",    32'(bus.lcd_sf), 32'h1);

    // Single status read
    nib[0] = 4'h8; nib[1] = 4'h3;
    b = v_idx.size(); r = e_rise.size();
    start_read(1'b0, 1'b0, k);
    repeat (90) @(negedge clk);
    chk("t1_nvalid",   32'(v_idx.size() - b), 32'd1);
    chk("t1_vcycle",   32'(qget(v_idx, b)), 32'(k + 79));
    chk("t1_data",     32'(qget(v_dat, b)), 32'h83);
    chk("t1_timeout",  32'(qget(v_to, b)), 32'h0);
    chk("t1_e1_rise",  32'(qget(e_rise, r)), 32'(k + 3));
    chk("t1_e1_width", 32'(qget(e_fall, r) - qget(e_rise, r)), 32'd12);
    chk("t1_e_gap",    32'(qget(e_rise, r + 1) - (qget(e_fall, r) - 1)), 32'd52);
    chk("t1_e2_width", 32'(qget(e_fall, r + 1) - qget(e_rise, r + 1)), 32'd12);

    // Data read: RS held, ready low for the whole transaction
    nib[0] = 4'h4; nib[1] = 4'h1;
    b = v_idx.size();
    start_read(1'b1, 1'b1, k);
    bad = 0;
    repeat (79) begin
      @(negedge clk);
      if (bus.lcd_rs !== 1'b1 || bus.ready !== 1'b0) bad++;
    end
    repeat (5) @(negedge clk);
    chk("t2_rs_ready_bad", 32'(bad), 32'd0);
    chk("t2_data",  32'(qget(v_dat, b)), 32'h41);
    chk("t2_nvalid", 32'(v_idx.size() - b), 32'd1);

    // Busy poll: BF set for three reads, then clear
    nib[0] = 4'h8; nib[1] = 4'h0; nib[2] = 4'h8; nib[3] = 4'h1;
    nib[4] = 4'h9; nib[5] = 4'h2; nib[6] = 4'h0; nib[7] = 4'h5;
    b = v_idx.size(); r = e_rise.size();
    start_read(1'b0, 1'b1, k);
    repeat (480) @(negedge clk);
    chk("t3_nvalid",  32'(v_idx.size() - b), 32'd1);
    chk("t3_vcycle",  32'(qget(v_idx, b)), 32'(k + 466));
    chk("t3_data",    32'(qget(v_dat, b)), 32'h05);
    chk("t3_timeout", 32'(qget(v_to, b)), 32'h0);
    chk("t3_pulses",  32'(e_rise.size() - r), 32'd8);
    mn = 1000;
    for (int i = r; i + 1 < e_rise.size(); i++)
      if (e_rise[i + 1] - e_fall[i] < mn) mn = e_rise[i + 1] - e_fall[i];
    chk("t3_min_e_low_ge50", 32'(mn >= 50), 32'h1);

    // Poll timeout: BF never clears
    for (int i = 0; i < 8; i++) nib[i] = 4'hF;
    b = v_idx.size();
    start_read(1'b0, 1'b1, k);
    repeat (480) @(negedge clk);
    chk("t4_nvalid",  32'(v_idx.size() - b), 32'd1);
    chk("t4_vcycle",  32'(qget(v_idx, b)), 32'(k + 466));
    chk("t4_data",    32'(qget(v_dat, b)), 32'hFF);
    chk("t4_timeout", 32'(qget(v_to, b)), 32'h1);

    // Reset in the middle of the LSN pulse
    nib[0] = 4'h4; nib[1] = 4'h1;
    b = v_idx.size();
    start_read(1'b0, 1'b0, k);
    repeat (70) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_e",     32'(bus.lcd_e), 32'h0);
    chk("t5_rw",    32'(bus.lcd_rw), 32'h0);
    chk("t5_ready", 32'(bus.ready), 32'h1);
    repeat (100) @(negedge clk);
    chk("t5_no_valid", 32'(v_idx.size() - b), 32'd0);
    nib[0] = 4'h2; nib[1] = 4'h7;
    start_read(1'b1, 1'b0, k);
    repeat (90) @(negedge clk);
    chk("t5_after_data", 32'(qget(v_dat, b)), 32'h27);

    // Request held high: one accept per transaction
    for (int i = 0; i < 32; i++) nib[i] = (i % 2 == 0) ? 4'h4 : 4'h1;
    b = v_idx.size();
    wait_ready();
    txn_id++;
    bus.read_rs      = 1'b1;
    bus.read_poll    = 1'b0;
    bus.read_request = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    repeat (200) @(negedge clk);
    bus.read_request = 1'b0;
    repeat (100) @(negedge clk);
    chk("t6_nvalid", 32'(v_idx.size() - b), 32'd3);
    chk("t6_first",  32'(qget(v_idx, b)), 32'(k + 79));
    chk("t6_space1", 32'(qget(v_idx, b + 1) - qget(v_idx, b)), 32'd80);
    chk("t6_space2", 32'(qget(v_idx, b + 2) - qget(v_idx, b + 1)), 32'd80);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/lcd_reader.md
# lcd_reader

Read-side companion to the LCD write controller: performs HD44780-style 4-bit reads (busy flag/address counter with RS=0, DDRAM/CGRAM data with RS=1) from the character LCD. It handles the RW/RS setup, E pulse and nibble timing, and assembles the MSN and LSN into one byte. An optional busy-poll mode repeats status reads until the busy flag clears. It sits between the LCD pins and the command sequencer, which uses it to replace fixed post-command delays with busy-flag polling.

## Interface
- SETUP_CYCLES, 2: cycles RS/RW are stable before E rises (≥40 ns at 50 MHz).
- E_HIGH_CYCLES, 12: E high width per nibble (≥230 ns).
- HOLD_CYCLES, 1: cycles RS/RW are held after E falls.
- GAP_CYCLES, 50: E low time between MSN and LSN pulses (≥1 µs).
- POLL_LIMIT, 1000: maximum status reads per poll request before timeout.
- Clock  in  1  system clock, single domain.
- Reset  in  1  synchronous, active-high.
- iRead_Request  in  1  start a read; sampled only when oReady=1.
- iRead_RS  in  1  0 = status/address read, 1 = data read; captured at accept.
- iRead_Poll  in  1  captured at accept; honoured only when iRead_RS=0.
- iLCD_Data  in  4  LCD DB7..DB4.
- oReady  out  1  high in IDLE only.
- oRead_Valid  out  1  one-cycle pulse; oRead_Data valid in the same cycle.
- oRead_Data  out  8  {MSN,LSN}; holds its value until the next oRead_Valid.
- oTimeout  out  1  one-cycle pulse together with oRead_Valid when the poll limit is hit.
- oLCD_Enabled  out  1  LCD E.
- oLCD_RegisterSelect  out  1  LCD RS.
- oLCD_ReadWrite  out  1  LCD RW; 1 only during a transaction.
- oLCD_StrataFlashControl  out  1  constant 1.

## Operation
- States: IDLE → SETUP → E_MSN → HOLD_MSN → GAP → E_LSN → HOLD_LSN → DONE → IDLE.
- A single 16-bit down counter times each state. It is loaded with (N−1) on entry, and the state advances when the counter reaches 0.
- IDLE: oReady=1, E=0, RW=0. A request with oReady=1 latches RS and poll (poll=iRead_Poll & ~iRead_RS), clears the poll counter and enters SETUP.
- SETUP: RW=1, RS=latched value, E=0.
- E_MSN/E_LSN: E=1. iLCD_Data is sampled on the last cycle of the state into the MSN/LSN register.
- HOLD_*: E=0, RW/RS unchanged. GAP: E=0, RW=1.
- DONE: drive oRead_Data={MSN,LSN}. Then:
  - If poll=0: pulse oRead_Valid and go to IDLE.
  - If poll=1 and bit7=0: pulse oRead_Valid and go to IDLE.
  - If poll=1 and bit7=1: increment the poll counter. If it equals POLL_LIMIT, pulse oRead_Valid and oTimeout, then go to IDLE. Otherwise go to GAP, then SETUP, for the next read; this keeps the ≥1 µs E-low spacing.
- Requests made while oReady=0 are ignored, not queued.
- The block never drives DB; the upper level may only enable its own DB drivers while oLCD_ReadWrite=0.

## Timing
- Reset: oReady=1 from the first cycle after reset deasserts. All other outputs are 0, oRead_Data=8'h00, and oLCD_StrataFlashControl=1.
- Reset mid-transaction: IDLE on the next edge. E and RW go low that cycle, and no valid or timeout pulse is produced.
- Accept at edge k. SETUP occupies cycles k+1..k+2 and E is high in cycles k+3..k+14 (defaults).
- Single-read latency: oRead_Valid is high in cycle k+1+SETUP+2·E_HIGH+2·HOLD+GAP, which is k+79 with defaults. oReady returns at k+80.
- Back-to-back: a request in the cycle oReady reappears is accepted, giving an 80-cycle minimum period.
- Each poll iteration beyond the first adds GAP+SETUP+2·E_HIGH+2·HOLD+GAP+1 cycles (129 with defaults).
- oLCD_RegisterSelect is stable from SETUP entry through the end of HOLD_LSN. A new iRead_RS value never affects an active transaction.

## Test plan
- Single status read: iLCD_Data=4'h8 during E_MSN, 4'h3 during E_LSN, RS=0 → oRead_Data=8'h83 and oRead_Valid at k+79. RS=0, RW=1, E high exactly 12 cycles twice, E-low gap of 52 cycles.
- Data read: RS=1, nibbles 4'h4/4'h1 → 8'h41. RS stays 1 through HOLD_LSN, and oReady is low throughout.
- Busy poll: BF=1 for 3 reads, then 4'h0/4'h5 → exactly one oRead_Valid with 8'h05 and no oTimeout. Four E_MSN pulses, and E-low spacing ≥50 cycles everywhere.
- Timeout: POLL_LIMIT=4, BF held 1 with nibbles 4'hF/4'hF → oRead_Valid and oTimeout in the same cycle after the 4th read, oRead_Data=8'hFF.
- Reset during E_LSN → E=0, RW=0 and oReady=1 on the next cycle. No oRead_Valid. A subsequent read completes normally.
- Request held high continuously → only one accept per transaction, 80-cycle spacing between valid pulses, and no request is accepted while oReady=0.
